// File: rtl/udp_rx_demux.sv
// UDP receive stage: parses the 8-byte header, filters on destination port and
// forwards the length-framed payload through a single output register.
module udp_rx_demux #(
    parameter int                       NUM_PORTS      = 4,
    parameter logic [16*NUM_PORTS-1:0]  PORT_LIST      = {16'd5003, 16'd5002, 16'd5001, 16'd5000},
    parameter int                       DEST_W         = 2,
    parameter bit                       DROP_UNMATCHED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic [DEST_W-1:0] m_axis_tdest,
    input  logic              m_axis_tready,
    output logic              hdr_valid,
    output logic [15:0]       hdr_src_port,
    output logic [15:0]       hdr_dst_port,
    output logic [15:0]       hdr_length,
    output logic [15:0]       hdr_checksum,
    output logic              hdr_match,
    output logic              err_len,
    output logic              err_drop
);

    // state   | meaning
    // HDR     | collecting header bytes 0-7
    // PAYLOAD | forwarding payload bytes, remain counts down to the last one
    // DROP    | discarding bytes until upstream tlast
    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

    state_t              state, state_n;
    logic [2:0]          byte_cnt;
    logic [55:0]         hdr_shift;
    logic [15:0]         remain, remain_n;
    logic [DEST_W-1:0]   cur_dest;
    logic [DEST_W-1:0]   match_idx;
    logic                match_hit;
    logic                s_fire;
    logic                hdr_load, beat_load, beat_last;
    logic                err_len_n, err_drop_n;
    logic [63:0]         hdr_full;
    logic [15:0]         len_now, dst_now;

    assign s_axis_tready = (state == PAYLOAD) ? (!m_axis_tvalid || m_axis_tready) : 1'b1;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign hdr_full      = {hdr_shift, s_axis_tdata};
    assign dst_now       = hdr_full[47:32];
    assign len_now       = hdr_full[31:16];
    assign beat_last     = (remain == 16'd1) || s_axis_tlast;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        match_idx = '0;
        match_hit = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (dst_now == PORT_LIST[16*i +: 16]) begin
                match_idx = DEST_W'(i);
                match_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        remain_n   = remain;
        hdr_load   = 1'b0;
        beat_load  = 1'b0;
        err_len_n  = 1'b0;
        err_drop_n = 1'b0;
        case (state)
            HDR: begin
                if (s_fire) begin
                    if (byte_cnt == 3'd7) begin
                        if (len_now < 16'd8) begin
                            err_len_n = 1'b1;
                            state_n   = s_axis_tlast ? HDR : DROP;
                        end else if (len_now > 16'd8 && s_axis_tlast) begin
                            err_len_n = 1'b1;
                        end else if (!match_hit && DROP_UNMATCHED) begin
                            err_drop_n = 1'b1;
                            state_n    = s_axis_tlast ? HDR : DROP;
                        end else begin
                            hdr_load = 1'b1;
                            remain_n = len_now - 16'd8;
                            if (len_now == 16'd8)
                                state_n = s_axis_tlast ? HDR : DROP;
                            else
                                state_n = PAYLOAD;
                        end
                    end else if (s_axis_tlast) begin
                        err_len_n = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (s_fire) begin
                    beat_load = 1'b1;
                    remain_n  = remain - 16'd1;
                    if (remain == 16'd1) begin
                        state_n = s_axis_tlast ? HDR : DROP;
                    end else if (s_axis_tlast) begin
                        err_len_n = 1'b1;
                        state_n   = HDR;
                    end
                end
            end
            DROP: begin
                if (s_fire && s_axis_tlast)
                    state_n = HDR;
            end
            default: state_n = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HDR;
            byte_cnt      <= '0;
            hdr_shift     <= '0;
            remain        <= '0;
            cur_dest      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= '0;
            hdr_valid     <= 1'b0;
            hdr_src_port  <= '0;
            hdr_dst_port  <= '0;
            hdr_length    <= '0;
            hdr_checksum  <= '0;
            hdr_match     <= 1'b0;
            err_len       <= 1'b0;
            err_drop      <= 1'b0;
        end else begin
            state     <= state_n;
            remain    <= remain_n;
            hdr_valid <= hdr_load;
            err_len   <= err_len_n;
            err_drop  <= err_drop_n;
            if (state == HDR && s_fire) begin
                hdr_shift <= {hdr_shift[47:0], s_axis_tdata};
                byte_cnt  <= s_axis_tlast ? 3'd0 : byte_cnt + 3'd1;
            end
            if (hdr_load) begin
                hdr_src_port <= hdr_full[63:48];
                hdr_dst_port <= dst_now;
                hdr_length   <= len_now;
                hdr_checksum <= hdr_full[15:0];
                hdr_match    <= match_hit;
                cur_dest     <= match_idx;
            end
            // Output register: drain first, a new beat in the same cycle overrides.
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (beat_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= beat_last;
                m_axis_tdest  <= cur_dest;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_demux.sv
// Scoreboard bench for udp_rx_demux: two instances (drop / forward unmatched)
// share the input stream; expected beats are queued as frames are built.
module tb_udp_rx_demux;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } tx_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [1:0] dest;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       m_ready = 1'b1;
    bit         rand_ready = 1'b0;

    logic       s_ready0, s_ready1;
    logic [7:0] m_data0, m_data1;
    logic       m_valid0, m_valid1, m_last0, m_last1;
    logic [1:0] m_dest0, m_dest1;
    logic       hv0, hv1, match0, match1, el0, el1, ed0, ed1;
    logic [15:0] src0, dst0, len0, cs0, src1, dst1, len1, cs1;

    int n_checks = 0;
    int n_fail = 0;
    int hv_cnt0 = 0, el_cnt0 = 0, ed_cnt0 = 0, hv_cnt1 = 0;

    tx_t  tx_q[$];
    exp_t exp0[$];
    exp_t exp1[$];

    udp_rx_demux dut0 (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_ready0),
        .m_axis_tdata(m_data0), .m_axis_tvalid(m_valid0), .m_axis_tlast(m_last0), .m_axis_tdest(m_dest0),
        .m_axis_tready(m_ready),
        .hdr_valid(hv0), .hdr_src_port(src0), .hdr_dst_port(dst0), .hdr_length(len0), .hdr_checksum(cs0),
        .hdr_match(match0), .err_len(el0), .err_drop(ed0)
    );

    udp_rx_demux #(.DROP_UNMATCHED(1'b0)) dut1 (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_ready1),
        .m_axis_tdata(m_data1), .m_axis_tvalid(m_valid1), .m_axis_tlast(m_last1), .m_axis_tdest(m_dest1),
        .m_axis_tready(m_ready),
        .hdr_valid(hv1), .hdr_src_port(src1), .hdr_dst_port(dst1), .hdr_length(len1), .hdr_checksum(cs1),
        .hdr_match(match1), .err_len(el1), .err_drop(ed1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (rand_ready) m_ready = ($urandom_range(0, 1) == 1);
    end

    // Output monitor: beats are compared against the queues, stalled beats must hold.
    bit         hold0 = 1'b0;
    logic [7:0] hold_d0;
    logic       hold_l0;
    always @(negedge clk) begin
        if (reset) begin
            hold0 = 1'b0;
        end else begin
            if (hv0) hv_cnt0++;
            if (el0) el_cnt0++;
            if (ed0) ed_cnt0++;
            if (hv1) hv_cnt1++;
            if (hold0) begin
                n_checks++;
                if (m_valid0 !== 1'b1 || m_data0 !== hold_d0 || m_last0 !== hold_l0) begin
                    n_fail++;
                    $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             m_valid0, m_data0, m_last0, hold_d0, hold_l0);
                end
            end
            hold0 = m_valid0 && !m_ready;
            hold_d0 = m_data0;
            hold_l0 = m_last0;
            if (!s_ready0) begin
                n_checks++;
                if (!(m_valid0 && !m_ready)) begin
                    n_fail++;
                    $display("FAIL s_ready_low: s_ready=0 with m_valid=%b m_ready=%b, required full and stalled",
                             m_valid0, m_ready);
                end
            end
            if (m_valid0 && m_ready) begin
                exp_t e;
                n_checks++;
                if (exp0.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat0_unexpected: got data=%h last=%b, required no beat", m_data0, m_last0);
                end else begin
                    e = exp0.pop_front();
                    if (m_data0 !== e.d || m_last0 !== e.l || m_dest0 !== e.dest) begin
                        n_fail++;
                        $display("FAIL beat0: got data=%h last=%b dest=%0d, required data=%h last=%b dest=%0d",
                                 m_data0, m_last0, m_dest0, e.d, e.l, e.dest);
                    end
                end
            end
            if (m_valid1 && m_ready) begin
                exp_t e;
                n_checks++;
                if (exp1.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat1_unexpected: got data=%h last=%b, required no beat", m_data1, m_last1);
                end else begin
                    e = exp1.pop_front();
                    if (m_data1 !== e.d || m_last1 !== e.l || m_dest1 !== e.dest) begin
                        n_fail++;
                        $display("FAIL beat1: got data=%h last=%b dest=%0d, required data=%h last=%b dest=%0d",
                                 m_data1, m_last1, m_dest1, e.d, e.l, e.dest);
                    end
                end
            end
        end
    end

    task automatic push_tx(input logic [7:0] d, input logic l);
        tx_t t;
        t.d = d;
        t.l = l;
        tx_q.push_back(t);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l, input logic [1:0] dest,
                            input bit to0, input bit to1);
        exp_t e;
        e.d = d;
        e.l = l;
        e.dest = dest;
        if (to0) exp0.push_back(e);
        if (to1) exp1.push_back(e);
    endtask

    task automatic push_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                            input logic [15:0] cs, input logic last7);
        push_tx(src[15:8], 1'b0); push_tx(src[7:0], 1'b0);
        push_tx(dst[15:8], 1'b0); push_tx(dst[7:0], 1'b0);
        push_tx(len[15:8], 1'b0); push_tx(len[7:0], 1'b0);
        push_tx(cs[15:8], 1'b0);  push_tx(cs[7:0], last7);
    endtask

    // Sends every queued byte; each call starts and ends just after a rising edge.
    task automatic send_all();
        tx_t t;
        while (tx_q.size() > 0) begin
            int  n = 0;
            bit  done = 1'b0;
            t = tx_q.pop_front();
            s_tdata = t.d;
            s_tlast = t.l;
            s_tvalid = 1'b1;
            while (!done) begin
                @(negedge clk);
                if (s_ready0) done = 1'b1;
                else begin
                    n++;
                    if (n > 2000) begin
                        n_fail++;
                        $display("FAIL send_timeout: s_ready stuck at 0, required 1 within 2000 cycles");
                        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                        $fatal(1);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d/%0d beats outstanding, required 0/0", name, exp0.size(), exp1.size());
        end
    endtask

    task automatic clear_counts();
        hv_cnt0 = 0; el_cnt0 = 0; ed_cnt0 = 0; hv_cnt1 = 0;
    endtask

    task automatic check_counts(input string name, input int hv, input int el, input int ed);
        n_checks++;
        if (hv_cnt0 != hv || el_cnt0 != el || ed_cnt0 != ed) begin
            n_fail++;
            $display("FAIL %s_pulses: hdr_valid=%0d err_len=%0d err_drop=%0d, required %0d %0d %0d",
                     name, hv_cnt0, el_cnt0, ed_cnt0, hv, el, ed);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (s_ready0 !== 1'b1 || m_valid0 !== 1'b0 || m_last0 !== 1'b0 || m_data0 !== 8'h00 || m_dest0 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_stream: s_ready=%b m_valid=%b m_last=%b m_data=%h m_dest=%0d, required 1 0 0 00 0",
                     s_ready0, m_valid0, m_last0, m_data0, m_dest0);
        end
        n_checks++;
        if (hv0 !== 1'b0 || el0 !== 1'b0 || ed0 !== 1'b0 || match0 !== 1'b0 ||
            src0 !== 16'h0 || dst0 !== 16'h0 || len0 !== 16'h0 || cs0 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_hdr: hv=%b el=%b ed=%b match=%b src=%h dst=%h len=%h cs=%h, required all 0",
                     hv0, el0, ed0, match0, src0, dst0, len0, cs0);
        end
    endtask

    task automatic test_basic();
        clear_counts();
        push_hdr(16'h1234, 16'd5001, 16'd12, 16'hBEEF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_tx(8'hA1 + 8'(i), i == 3);
            push_exp(8'hA1 + 8'(i), i == 3, 2'd1, 1'b1, 1'b1);
        end
        send_all();
        drain("basic");
        check_counts("basic", 1, 0, 0);
        n_checks++;
        if (src0 !== 16'h1234 || dst0 !== 16'd5001 || len0 !== 16'd12 || cs0 !== 16'hBEEF || match0 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hdr: src=%h dst=%0d len=%0d cs=%h match=%b, required 1234 5001 12 beef 1",
                     src0, dst0, len0, cs0, match0);
        end
    endtask

    task automatic test_padding();
        clear_counts();
        push_hdr(16'h0BAD, 16'd5001, 16'd12, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_tx(8'hA1 + 8'(i), 1'b0);
            push_exp(8'hA1 + 8'(i), i == 3, 2'd1, 1'b1, 1'b1);
        end
        for (int i = 0; i < 6; i++) push_tx(8'h00, i == 5);
        send_all();
        drain("padding");
        check_counts("padding", 1, 0, 0);
    endtask

    task automatic test_short_frame();
        clear_counts();
        push_hdr(16'h0001, 16'd5003, 16'd20, 16'h1111, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_tx(8'h50 + 8'(i), i == 3);
            push_exp(8'h50 + 8'(i), i == 3, 2'd3, 1'b1, 1'b1);
        end
        send_all();
        drain("short");
        check_counts("short", 1, 1, 0);
        clear_counts();
        push_hdr(16'h0002, 16'd5000, 16'd10, 16'h2222, 1'b0);
        push_tx(8'h61, 1'b0); push_exp(8'h61, 1'b0, 2'd0, 1'b1, 1'b1);
        push_tx(8'h62, 1'b1); push_exp(8'h62, 1'b1, 2'd0, 1'b1, 1'b1);
        send_all();
        drain("after_short");
        check_counts("after_short", 1, 0, 0);
        n_checks++;
        if (dst0 !== 16'd5000 || len0 !== 16'd10) begin
            n_fail++;
            $display("FAIL after_short_hdr: dst=%0d len=%0d, required 5000 10", dst0, len0);
        end
    endtask

    task automatic test_boundaries();
        clear_counts();
        // tlast inside the header: error, no output, parser restarts at byte 0
        push_tx(8'h01, 1'b0); push_tx(8'h02, 1'b0); push_tx(8'h03, 1'b0); push_tx(8'h04, 1'b1);
        send_all();
        drain("hdr_tlast");
        check_counts("hdr_tlast", 0, 1, 0);
        clear_counts();
        push_hdr(16'h0003, 16'd5000, 16'd5, 16'h0000, 1'b1);
        send_all();
        drain("len_lt8");
        check_counts("len_lt8", 0, 1, 0);
        clear_counts();
        push_hdr(16'h0004, 16'd5002, 16'd8, 16'h3333, 1'b0);
        push_tx(8'hEE, 1'b0); push_tx(8'hEF, 1'b1);
        send_all();
        drain("len_eq8");
        check_counts("len_eq8", 1, 0, 0);
        n_checks++;
        if (dst0 !== 16'd5002 || len0 !== 16'd8) begin
            n_fail++;
            $display("FAIL len_eq8_hdr: dst=%0d len=%0d, required 5002 8", dst0, len0);
        end
    endtask

    task automatic test_unmatched();
        clear_counts();
        push_hdr(16'h0005, 16'd6000, 16'd11, 16'h4444, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_tx(8'h70 + 8'(i), i == 2);
            push_exp(8'h70 + 8'(i), i == 2, 2'd0, 1'b0, 1'b1);
        end
        send_all();
        drain("unmatched");
        check_counts("unmatched", 0, 0, 1);
        n_checks++;
        if (dst0 !== 16'd5002) begin
            n_fail++;
            $display("FAIL unmatched_hold: dut0 hdr_dst=%0d, required 5002 (unchanged)", dst0);
        end
        n_checks++;
        if (hv_cnt1 != 1 || match1 !== 1'b0 || dst1 !== 16'd6000) begin
            n_fail++;
            $display("FAIL unmatched_fwd: dut1 hdr_valid=%0d match=%b dst=%0d, required 1 0 6000",
                     hv_cnt1, match1, dst1);
        end
    endtask

    task automatic test_backpressure();
        clear_counts();
        push_hdr(16'h0006, 16'd5003, 16'd72, 16'h5555, 1'b0);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            push_tx(d, i == 63);
            push_exp(d, i == 63, 2'd3, 1'b1, 1'b1);
        end
        rand_ready = 1'b1;
        send_all();
        drain("backpressure");
        rand_ready = 1'b0;
        #3;
        m_ready = 1'b1;
        check_counts("backpressure", 1, 0, 0);
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        push_hdr(16'h0007, 16'd5001, 16'd20, 16'h6666, 1'b0);
        push_tx(8'h99, 1'b0);
        send_all();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (m_valid0 !== 1'b0 || s_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: m_valid=%b s_ready=%b, required 0 1", m_valid0, s_ready0);
        end
        m_ready = 1'b1;
        clear_counts();
        push_hdr(16'h0008, 16'd5002, 16'd11, 16'h7777, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_tx(8'hC0 + 8'(i), i == 2);
            push_exp(8'hC0 + 8'(i), i == 2, 2'd2, 1'b1, 1'b1);
        end
        send_all();
        drain("after_reset");
        check_counts("after_reset", 1, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_padding();
        test_short_frame();
        test_boundaries();
        test_unmatched();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
